// File: rtl/iir_seq_pkg.sv
// Shared types and default widths for the IIR MAC sequencer.
package iir_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MAC_B,
        MAC_A,
        SCALE,
        OUT
    } state_e;

    typedef enum logic [1:0] {
        MAC_NOP,
        MAC_CLR,
        MAC_ADD,
        MAC_SUB
    } mac_op_e;

    localparam logic CFG_SEL_B = 1'b0;
    localparam logic CFG_SEL_A = 1'b1;

    localparam int unsigned DEF_ORDER     = 10;
    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_COEF_W    = 32;
    localparam int unsigned DEF_FRAC_BITS = 16;
    localparam int unsigned DEF_ACC_W     = 72;

endpackage

// File: rtl/iir_mac_sequencer_if.sv
// Sample stream bundle: input side (x[n]) and output side (y[n]) valid/ready channels.
interface iir_mac_sequencer_if #(
    parameter int unsigned DATA_W = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/iir_mac_unit.sv
// Shared signed multiply-accumulate unit with clear/add/subtract operations.
module iir_mac_unit
    import iir_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned COEF_W = DEF_COEF_W,
    parameter int unsigned ACC_W  = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  mac_op_e                  op,
    input  logic signed [DATA_W-1:0] data,
    input  logic signed [COEF_W-1:0] coef,
    output logic signed [ACC_W-1:0]  acc
);
    logic signed [DATA_W+COEF_W-1:0] prod;
    logic signed [ACC_W-1:0]         prod_ext;

    assign prod     = data * coef;
    assign prod_ext = ACC_W'(prod);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else begin
            case (op)
                MAC_CLR: acc <= '0;
                MAC_ADD: acc <= acc + prod_ext;
                MAC_SUB: acc <= acc - prod_ext;
                default: acc <= acc;
            endcase
        end
    end
endmodule

// File: rtl/iir_mac_sequencer.sv
// Time-multiplexed direct-form-I IIR filter stepping one MAC over b and a taps per sample.
// Define IIR_SEQ_SAT_EN to saturate the scaled result; otherwise it wraps to DATA_W bits.
module iir_mac_sequencer
    import iir_seq_pkg::*;
#(
    parameter int unsigned ORDER     = DEF_ORDER,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned COEF_W    = DEF_COEF_W,
    parameter int unsigned FRAC_BITS = DEF_FRAC_BITS,
    parameter int unsigned ACC_W     = DEF_ACC_W
) (
    input  logic                             clk,
    input  logic                             rst,
    iir_mac_sequencer_if.slave               strm,
    input  logic                             cfg_we,
    input  logic                             cfg_sel,
    input  logic [$clog2(ORDER+1)-1:0]       cfg_addr,
    input  logic signed [COEF_W-1:0]         cfg_wdata,
    input  logic                             clear,
    output logic                             busy,
    output logic                             cfg_err
);
    localparam int unsigned     AW       = $clog2(ORDER + 1);
    localparam logic [AW-1:0]   LAST_TAP = AW'(ORDER);

    state_e                   state, state_nxt;
    mac_op_e                  mac_op;
    logic [AW-1:0]            tap, head, hist_idx;
    logic signed [COEF_W-1:0] b_coef [ORDER+1];
    logic signed [COEF_W-1:0] a_coef [ORDER+1];
    logic signed [DATA_W-1:0] x_hist [ORDER+1];
    logic signed [DATA_W-1:0] y_hist [ORDER+1];
    logic signed [DATA_W-1:0] mac_data, y_next;
    logic signed [COEF_W-1:0] mac_coef;
    logic signed [ACC_W-1:0]  acc;
    logic                     accept, cfg_ok;

    assign strm.in_ready = (state == IDLE) && !cfg_we && !clear;
    assign accept        = strm.in_ready && strm.in_valid;
    assign cfg_ok        = cfg_we && (state == IDLE) && !clear && (cfg_addr <= LAST_TAP);
    assign busy          = (state != IDLE);

    // Sample n-k lives 'tap' slots behind the head in both circular histories.
    always_comb begin
        hist_idx = '0;
        if (head >= tap)
            hist_idx = head - tap;
        else
            hist_idx = AW'(({1'b0, head} + (AW+1)'(ORDER + 1)) - {1'b0, tap});
    end

    always_comb begin
        mac_data = x_hist[hist_idx];
        mac_coef = b_coef[tap];
        if (state == MAC_A) begin
            mac_data = y_hist[hist_idx];
            mac_coef = a_coef[tap];
        end
    end

`ifdef IIR_SEQ_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    logic signed [ACC_W-1:0] scaled;

    always_comb begin
        scaled = acc >>> FRAC_BITS;
        y_next = scaled[DATA_W-1:0];
        if (scaled > SAT_HI)
            y_next = {1'b0, {(DATA_W-1){1'b1}}};
        else if (scaled < SAT_LO)
            y_next = {1'b1, {(DATA_W-1){1'b0}}};
    end
`else
    always_comb begin
        y_next = DATA_W'(acc >>> FRAC_BITS);
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mac_op    = MAC_NOP;
        if (clear) begin
            state_nxt = IDLE;
            mac_op    = MAC_CLR;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_nxt = MAC_B;
                        mac_op    = MAC_CLR;
                    end
                end
                MAC_B: begin
                    mac_op = MAC_ADD;
                    if (tap == LAST_TAP) state_nxt = MAC_A;
                end
                MAC_A: begin
                    mac_op = MAC_SUB;
                    if (tap == LAST_TAP) state_nxt = SCALE;
                end
                SCALE:   state_nxt = OUT;
                OUT:     if (strm.out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tap           <= '0;
            head          <= '0;
            strm.out_valid <= 1'b0;
            strm.out_data  <= '0;
            cfg_err       <= 1'b0;
            for (int unsigned i = 0; i <= ORDER; i++) begin
                b_coef[i] <= '0;
                a_coef[i] <= '0;
                x_hist[i] <= '0;
                y_hist[i] <= '0;
            end
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_ok) begin
                if (cfg_sel == CFG_SEL_A)
                    a_coef[cfg_addr] <= cfg_wdata;
                else
                    b_coef[cfg_addr] <= cfg_wdata;
            end
            if (clear) begin
                tap           <= '0;
                head          <= '0;
                strm.out_valid <= 1'b0;
                for (int unsigned i = 0; i <= ORDER; i++) begin
                    x_hist[i] <= '0;
                    y_hist[i] <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            x_hist[head] <= strm.in_data;
                            tap          <= '0;
                        end
                    end
                    // a taps start at k=1, so the counter skips index 0 on the bank switch.
                    MAC_B: tap <= (tap == LAST_TAP) ? AW'(1) : tap + AW'(1);
                    MAC_A: tap <= tap + AW'(1);
                    SCALE: begin
                        strm.out_data  <= y_next;
                        strm.out_valid <= 1'b1;
                    end
                    OUT: begin
                        if (strm.out_ready) begin
                            y_hist[head]   <= strm.out_data;
                            head           <= (head == LAST_TAP) ? '0 : head + AW'(1);
                            strm.out_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    iir_mac_unit #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk  (clk),
        .rst  (rst),
        .op   (mac_op),
        .data (mac_data),
        .coef (mac_coef),
        .acc  (acc)
    );
endmodule

// File: tb/tb_iir_mac_sequencer.sv
// Self-checking bench for iir_mac_sequencer: directed literal cases plus randomized traffic vs a sample-level model.
module tb_iir_mac_sequencer;
    localparam int ORDER = 10;
    localparam int DW    = 32;
    localparam int LAT   = 2 * ORDER + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic              cfg_sel = 1'b0;
    logic [3:0]        cfg_addr = '0;
    logic signed [31:0] cfg_wdata = '0;
    logic              clear = 1'b0;
    logic              busy, cfg_err;

    int n_cmp = 0;
    int n_bad = 0;

    iir_mac_sequencer_if #(.DATA_W(DW)) bus ();

    iir_mac_sequencer #(
        .ORDER(ORDER), .DATA_W(DW), .COEF_W(32), .FRAC_BITS(16), .ACC_W(72)
    ) dut (
        .clk(clk), .rst(rst), .strm(bus), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .clear(clear),
        .busy(busy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- sample-level reference model ----------------
    logic signed [31:0] m_b [0:ORDER];
    logic signed [31:0] m_a [0:ORDER];
    logic signed [31:0] m_xh [0:ORDER-1];   // m_xh[j] = x[n-1-j]
    logic signed [31:0] m_yh [0:ORDER-1];   // m_yh[j] = y[n-1-j]
    logic signed [31:0] m_y;
    int                 m_phase;            // 0 idle, 1 computing, 2 result pending
    int                 m_cnt;
    logic               m_ov, m_cfg_err;

    function automatic logic signed [31:0] model_y(input logic signed [31:0] xn);
        logic signed [127:0] s;
        logic signed [127:0] sh;
        s = m_b[0] * xn;
        for (int k = 1; k <= ORDER; k++) begin
            s = s + m_b[k] * m_xh[k-1];
            s = s - m_a[k] * m_yh[k-1];
        end
        sh = s >>> 16;
`ifdef IIR_SEQ_SAT_EN
        if (sh > 128'sd2147483647) return 32'sh7FFFFFFF;
        if (sh < -128'sd2147483648) return 32'sh80000000;
`endif
        return sh[31:0];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= 0; m_cnt <= 0; m_ov <= 1'b0; m_y <= '0; m_cfg_err <= 1'b0;
            for (int i = 0; i <= ORDER; i++) begin m_b[i] <= '0; m_a[i] <= '0; end
            for (int i = 0; i < ORDER; i++) begin m_xh[i] <= '0; m_yh[i] <= '0; end
        end else begin
            m_cfg_err <= cfg_we && !(m_phase == 0 && !clear && cfg_addr <= ORDER);
            if (clear) begin
                m_phase <= 0; m_ov <= 1'b0;
                for (int i = 0; i < ORDER; i++) begin m_xh[i] <= '0; m_yh[i] <= '0; end
            end else begin
                if (cfg_we && m_phase == 0 && cfg_addr <= ORDER) begin
                    if (cfg_sel) m_a[cfg_addr] <= cfg_wdata;
                    else         m_b[cfg_addr] <= cfg_wdata;
                end
                case (m_phase)
                    0: if (bus.in_valid && !cfg_we) begin
                        m_y     <= model_y(bus.in_data);
                        m_xh[0] <= bus.in_data;
                        for (int i = 1; i < ORDER; i++) m_xh[i] <= m_xh[i-1];
                        m_phase <= 1;
                        m_cnt   <= LAT;
                    end
                    1: if (m_cnt == 1) begin m_ov <= 1'b1; m_phase <= 2; end
                       else m_cnt <= m_cnt - 1;
                    default: if (bus.out_ready) begin
                        m_yh[0] <= m_y;
                        for (int i = 1; i < ORDER; i++) m_yh[i] <= m_yh[i-1];
                        m_ov <= 1'b0; m_phase <= 0;
                    end
                endcase
            end
        end
    end

    // Per-cycle compare, mid-cycle so inputs and outputs are settled.
    always @(negedge clk) begin
        if (rst) begin
            check("in_ready", bus.in_ready, (m_phase == 0) && !cfg_we && !clear);
            check("busy", busy, m_phase != 0);
            check("out_valid", bus.out_valid, m_ov);
            check("cfg_err", cfg_err, m_cfg_err);
            if (m_ov) check("out_data", bus.out_data, m_y);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic sel, input logic [3:0] addr, input logic signed [31:0] d,
                             output logic err);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = d;
        step();
        cfg_we = 1'b0;
        err = cfg_err;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic send(input logic signed [31:0] x, output logic signed [31:0] y, output int lat);
        int w;
        w = 0;
        while (!bus.in_ready && w < 200) begin step(); w++; end
        if (w >= 200) check("accept_wait", bus.in_ready, 1);
        bus.in_valid = 1'b1; bus.in_data = x;
        step();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin step(); lat++; end
        y = bus.out_data;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [31:0] y;
        logic               err, seen;
        int                 lat;

        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        step();

        // 1: reset state, idle produces nothing
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        seen = 1'b0;
        repeat (30) begin step(); seen |= bus.out_valid; end
        check("idle_no_output", seen, 0);

        // 2: identity b[0]
        cfg_write(1'b0, 4'd0, 32'sd65536, err);
        check("cfg_ok_err", err, 0);
        send(32'sd1234, y, lat);
        check("t2_latency", lat, LAT);
        check("t2_data", y, 32'sd1234);
        step();

        // 3: first-order recursion 0.5x + 0.5y
        pulse_clear();
        cfg_write(1'b0, 4'd0, 32'sd32768, err);
        cfg_write(1'b1, 4'd1, -32'sd32768, err);
        send(32'sd1000, y, lat); check("t3_y0", y, 32'sd500); step();
        send(32'sd1000, y, lat); check("t3_y1", y, 32'sd750); step();
        send(32'sd1000, y, lat); check("t3_y2", y, 32'sd875); step();

        // 4: backpressure hold, rejected write while busy
        bus.out_ready = 1'b0;
        send(32'sd1000, y, lat);
        check("t4_y3", y, 32'sd937);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_hold_data", bus.out_data, 32'sd937);
            check("t4_hold_in_ready", bus.in_ready, 0);
        end
        cfg_write(1'b0, 4'd0, 32'sd0, err);
        check("t4_cfg_err", err, 1);
        bus.out_ready = 1'b1;
        step();
        pulse_clear();
        send(32'sd1000, y, lat);
        check("t4_coef_kept", y, 32'sd500);
        step();

        // 5: overflow narrowing and bad address
        pulse_clear();
        cfg_write(1'b0, 4'd0, 32'sd262144, err);
        cfg_write(1'b1, 4'd1, 32'sd0, err);
        send(32'sh40000000, y, lat);
`ifdef IIR_SEQ_SAT_EN
        check("t5_sat", y, 32'sh7FFFFFFF);
`else
        check("t5_wrap", y, 32'sh00000000);
`endif
        step();
        cfg_write(1'b0, 4'd11, 32'sd123, err);
        check("t5_addr_err", err, 1);

        // 6: clear during MAC_A aborts the sample
        pulse_clear();
        cfg_write(1'b0, 4'd0, 32'sd65536, err);
        bus.in_valid = 1'b1; bus.in_data = 32'sd777;
        step();
        bus.in_valid = 1'b0;
        repeat (15) step();
        check("t6_busy_before", busy, 1);
        pulse_clear();
        check("t6_busy_after_clear", busy, 0);
        seen = 1'b0;
        repeat (30) begin step(); seen |= bus.out_valid; end
        check("t6_no_output", seen, 0);
        send(32'sd4321, y, lat);
        check("t6_latency", lat, LAT);
        check("t6_data", y, 32'sd4321);
        step();

        // Randomized traffic, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid  = $urandom_range(0, 1);
            bus.in_data   = $urandom;
            bus.out_ready = ($urandom_range(0, 9) < 7);
            clear         = ($urandom_range(0, 199) == 0);
            cfg_we        = !clear && ($urandom_range(0, 29) == 0);
            cfg_sel       = $urandom_range(0, 1);
            cfg_addr      = $urandom_range(0, 15);
            cfg_wdata     = $urandom_range(0, 131071) - 65536;
            step();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; clear = 1'b0; cfg_we = 1'b0;
        repeat (40) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
